// File: rtl/irq_event_scheduler.sv
// IRQ sequencer toward the monitor: power-up handshake phases, then video-format-change events.
// Owns the active-low status byte and INT line; clears and ID reads arrive as toggles from clk_rw.
module irq_event_scheduler #(
    parameter int CLK_HZ      = 50000000,
    parameter int HOLDOFF_CYC = 1000
) (
    input  logic       clk_50mhz_in,
    input  logic       reset,
    input  logic       clr_toggle,
    input  logic       id_toggle,
    input  logic [7:0] ph1_thr,
    input  logic [7:0] ph2_thr,
    input  logic [7:0] video_format,
    output logic [7:0] status_reg,
    output logic       int_x,
    output logic [7:0] latched_fmt,
    output logic [2:0] phase,
    output logic [7:0] elapsed_s
);

    // state    | meaning
    // S_BOOT   | boot IRQ (0xFD) pending, waiting for first clear
    // S_PH1    | waiting for ID read and phase-1 time
    // S_ACK1   | phase-1 IRQ (0xFB) asserted
    // S_PH2    | waiting for phase-2 time
    // S_ACK2   | phase-2 IRQ (0xEF) asserted
    // S_RUN    | watching for video format changes
    // S_ACKF   | format IRQ (0xDF) asserted
    typedef enum logic [2:0] {
        S_BOOT = 3'd0,
        S_PH1  = 3'd1,
        S_ACK1 = 3'd2,
        S_PH2  = 3'd3,
        S_ACK2 = 3'd4,
        S_RUN  = 3'd5,
        S_ACKF = 3'd6
    } state_t;

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int HW = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF_CYC - 1);

    state_t        state, state_nxt;
    logic [1:0]    sync1, sync2, hist;
    logic [1:0]    prime_cnt;
    logic [1:0]    edges;
    logic          clr_edge, id_edge;
    logic          id_seen, fmt_pend, fmt_pend_nxt;
    logic [7:0]    fmt_prev, status_nxt, latched_nxt;
    logic          fmt_change;
    logic [PW-1:0] presc;
    logic [HW-1:0] holdoff;
    logic          holdoff_idle;

    // Edges are ignored until the sync chain and history hold sampled levels, so a
    // toggle level present at reset release does not look like an event.
    assign edges        = (prime_cnt == 2'd3) ? (sync2 ^ hist) : 2'b00;
    assign clr_edge     = edges[0];
    assign id_edge      = edges[1];
    assign fmt_change   = (video_format != fmt_prev);
    assign holdoff_idle = (holdoff == '0);
    assign int_x        = (status_reg == 8'hFF);
    assign phase        = state;

    always_ff @(posedge clk_50mhz_in or posedge reset) begin
        if (reset) begin
            sync1     <= '0;
            sync2     <= '0;
            hist      <= '0;
            prime_cnt <= '0;
            id_seen   <= 1'b0;
            fmt_prev  <= '0;
            presc     <= '0;
            elapsed_s <= '0;
            holdoff   <= '0;
        end else begin
            sync1 <= {id_toggle, clr_toggle};
            sync2 <= sync1;
            hist  <= sync2;
            if (prime_cnt != 2'd3)
                prime_cnt <= prime_cnt + 2'd1;
            if (id_edge)
                id_seen <= 1'b1;
            fmt_prev <= video_format;
            if (presc == PRESC_MAX) begin
                presc <= '0;
                if (elapsed_s != 8'd255)
                    elapsed_s <= elapsed_s + 8'd1;
            end else begin
                presc <= presc + 1'b1;
            end
            if (clr_edge)
                holdoff <= HOLD_LOAD;
            else if (!holdoff_idle)
                holdoff <= holdoff - 1'b1;
        end
    end

    always_ff @(posedge clk_50mhz_in or posedge reset) begin
        if (reset) begin
            state       <= S_BOOT;
            status_reg  <= 8'hFD;
            latched_fmt <= '0;
            fmt_pend    <= 1'b0;
        end else begin
            state       <= state_nxt;
            status_reg  <= status_nxt;
            latched_fmt <= latched_nxt;
            fmt_pend    <= fmt_pend_nxt;
        end
    end

    // A clear edge always wins over a same-cycle assertion; holdoff then defers it.
    always_comb begin
        state_nxt    = state;
        status_nxt   = status_reg;
        latched_nxt  = latched_fmt;
        fmt_pend_nxt = fmt_pend | fmt_change;
        if (clr_edge)
            status_nxt = 8'hFF;
        case (state)
            S_BOOT: if (clr_edge) state_nxt = S_PH1;
            S_PH1: begin
                if (!clr_edge && id_seen && (elapsed_s > ph1_thr) && holdoff_idle) begin
                    status_nxt = 8'hFB;
                    state_nxt  = S_ACK1;
                end
            end
            S_ACK1: if (clr_edge) state_nxt = S_PH2;
            S_PH2: begin
                if (!clr_edge && (elapsed_s > ph2_thr) && holdoff_idle) begin
                    status_nxt = 8'hEF;
                    state_nxt  = S_ACK2;
                end
            end
            S_ACK2: if (clr_edge) state_nxt = S_RUN;
            S_RUN: begin
                if (!clr_edge && ((video_format != latched_fmt) || fmt_pend) && holdoff_idle) begin
                    latched_nxt  = video_format;
                    fmt_pend_nxt = 1'b0;
                    status_nxt   = 8'hDF;
                    state_nxt    = S_ACKF;
                end
            end
            S_ACKF: if (clr_edge) state_nxt = S_RUN;
            default: state_nxt = S_BOOT;
        endcase
    end

endmodule
